// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: keeps one imem read in flight, buffers {pc, instr} pairs
// for decode, and writes the next PC (sequential or redirect) back to the special register file.
module instr_fetch_unit #(
    parameter int ADDR_W     = 64,
    parameter int INSTR_W    = 32,
    parameter int PC_STEP    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc,
    output logic [2:0]         sr_write_addr,
    output logic [ADDR_W-1:0]  sr_write_data,
    output logic               sr_write_en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: imem_req stays high with a stable imem_addr until the cycle imem_ack is
    // sampled high; a decode transfer happens on every edge where instr_valid && instr_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        UPD   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               issue;
    logic               push;
    logic               pop;
    logic               flush;
    logic               fifo_full;
    logic               imem_req_nxt;
    logic [ADDR_W-1:0]  imem_addr_nxt;
    logic               sr_write_en_nxt;
    logic [ADDR_W-1:0]  sr_write_data_nxt;

    logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
    logic [INSTR_W-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    assign sr_write_addr = 3'b000;
    assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
    assign issue         = (state == IDLE) && !redirect && !stall && !fifo_full;
    assign flush         = redirect;
    assign pop           = (count != '0) && instr_ready && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect wins over everything: an unacked request must still be drained,
    // an acked one is simply discarded and the redirect write takes its UPD slot.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nxt = UPD;
                end else if (issue) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_nxt = imem_ack ? UPD : DRAIN;
                end else if (imem_ack) begin
                    state_nxt = UPD;
                end
            end
            UPD: begin
                state_nxt = redirect ? UPD : IDLE;
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_nxt = redirect ? UPD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req_nxt      = imem_req;
        imem_addr_nxt     = imem_addr;
        sr_write_en_nxt   = 1'b0;
        sr_write_data_nxt = sr_write_data;
        push              = 1'b0;
        if (issue) begin
            imem_req_nxt  = 1'b1;
            imem_addr_nxt = pc;
        end
        if ((state == REQ || state == DRAIN) && imem_ack) begin
            imem_req_nxt = 1'b0;
        end
        if (state == REQ && imem_ack && !redirect) begin
            push              = 1'b1;
            sr_write_en_nxt   = 1'b1;
            sr_write_data_nxt = imem_addr + ADDR_W'(PC_STEP);
        end
        if (redirect) begin
            sr_write_en_nxt   = 1'b1;
            sr_write_data_nxt = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            sr_write_en   <= 1'b0;
            sr_write_data <= '0;
        end else begin
            imem_req      <= imem_req_nxt;
            imem_addr     <= imem_addr_nxt;
            sr_write_en   <= sr_write_en_nxt;
            sr_write_data <= sr_write_data_nxt;
        end
    end

    // Issue only with a free slot and one request in flight, so push can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= imem_addr;
                data_mem[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign instr_valid = (count != '0);
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = addr_mem[rd_ptr];

endmodule
